// File: rtl/unidade_busca.sv
// unidade_busca: instruction fetch unit between the PC and the decoder.
// Issues one memory read at a time for the current PC word address and
// buffers {address, instruction} pairs in a FIFO for the decoder.
// Ports:
//   clock, reset (async, active-low)
//   endereco        current PC word address
//   avanca_pc       one-cycle pulse: PC advances once per pulse
//   mem_req/mem_endereco/mem_ack/mem_dado   memory read handshake
//   instr_valida/instr/instr_endereco/instr_pronto   decoder handshake
//   descarta        flush of buffered and in-flight instructions
module unidade_busca #(
  parameter int PROFUNDIDADE  = 4,
  parameter int LARGURA_INSTR = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [63:0]              endereco,
  output logic                     avanca_pc,
  output logic                     mem_req,
  output logic [63:0]              mem_endereco,
  input  logic                     mem_ack,
  input  logic [LARGURA_INSTR-1:0] mem_dado,
  output logic                     instr_valida,
  output logic [LARGURA_INSTR-1:0] instr,
  output logic [63:0]              instr_endereco,
  input  logic                     instr_pronto,
  input  logic                     descarta
);
  localparam int PW = $clog2(PROFUNDIDADE);
  localparam logic [PW:0] CHEIO = PROFUNDIDADE[PW:0];
  typedef enum logic [1:0] {OCIOSO, ESPERA, DESCARTE} estado_t;
  estado_t estado, prox;
  logic emite, aceita, pop;
  logic [PW:0] cont;
  logic [PW-1:0] ptr_le, ptr_es;
  logic [63:0] fila_end [PROFUNDIDADE];
  logic [LARGURA_INSTR-1:0] fila_dado [PROFUNDIDADE];
  assign instr_valida   = cont != '0;
  assign instr          = fila_dado[ptr_le];
  assign instr_endereco = fila_end[ptr_le];
  assign pop            = instr_valida & instr_pronto;
  // Issue only with a free slot: the outstanding read owns that slot, so a
  // push can never overflow even while pops are stalled.
  always_comb begin
    prox   = estado;
    emite  = 1'b0;
    aceita = 1'b0;
    case (estado)
      OCIOSO: begin
        emite = !descarta && cont < CHEIO;
        prox  = emite ? ESPERA : OCIOSO;
      end
      ESPERA: begin
        aceita = mem_ack && !descarta;
        prox   = mem_ack ? OCIOSO : descarta ? DESCARTE : ESPERA;
      end
      DESCARTE: prox = mem_ack ? OCIOSO : DESCARTE;
      default:  prox = OCIOSO;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= OCIOSO;
      mem_req      <= 1'b0;
      mem_endereco <= '0;
      avanca_pc    <= 1'b0;
    end else begin
      estado       <= prox;
      mem_req      <= prox != OCIOSO;
      mem_endereco <= emite ? endereco : mem_endereco;
      avanca_pc    <= aceita;
    end
  end
  // Flush wins over push and pop; storage is left as is, only the
  // occupancy and pointers are cleared.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cont   <= '0;
      ptr_le <= '0;
      ptr_es <= '0;
      for (int i = 0; i < PROFUNDIDADE; i++) begin
        fila_end[i]  <= '0;
        fila_dado[i] <= '0;
      end
    end else if (descarta) begin
      cont   <= '0;
      ptr_le <= '0;
      ptr_es <= '0;
    end else begin
      if (aceita) begin
        fila_end[ptr_es]  <= mem_endereco;
        fila_dado[ptr_es] <= mem_dado;
        ptr_es            <= ptr_es + 1'b1;
      end
      if (pop) ptr_le <= ptr_le + 1'b1;
      cont <= cont + {{PW{1'b0}}, aceita} - {{PW{1'b0}}, pop};
    end
  end
endmodule

// File: tb/tb_unidade_busca.sv
// tb_unidade_busca: self-checking bench for unidade_busca.
module tb_unidade_busca;
  logic        clock, reset;
  logic [63:0] endereco;
  logic        avanca_pc, mem_req;
  logic [63:0] mem_endereco;
  logic        mem_ack;
  logic [31:0] mem_dado;
  logic        instr_valida;
  logic [31:0] instr;
  logic [63:0] instr_endereco;
  logic        instr_pronto, descarta;
  typedef struct packed {logic [63:0] a; logic [31:0] d;} ent_t;
  typedef struct {int atraso; logic [31:0] dado; logic [63:0] end_esp;} vet_t;
  ent_t sb[$];
  int checks = 0, failures = 0, n_av = 0, av0 = 0;
  logic req_q = 1'b0, descartando = 1'b0;
  logic [63:0] req_end = '0;
  vet_t tab[3];
  unidade_busca #(.PROFUNDIDADE(4), .LARGURA_INSTR(32)) dut (
    .clock(clock), .reset(reset), .endereco(endereco), .avanca_pc(avanca_pc),
    .mem_req(mem_req), .mem_endereco(mem_endereco), .mem_ack(mem_ack),
    .mem_dado(mem_dado), .instr_valida(instr_valida), .instr(instr),
    .instr_endereco(instr_endereco), .instr_pronto(instr_pronto),
    .descarta(descarta)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic chk(input string nome, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", nome, got, exp);
    end
  endtask
  // One clock cycle: account for the edge given the inputs currently
  // driven, then advance to the next falling edge and update the PC model.
  task automatic step();
    ent_t e;
    if (instr_valida && instr_pronto) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_pop: DUT popped addr=0x%0h with nothing expected", instr_endereco);
      end else begin
        e = sb.pop_front();
        chk("pop_instr", {32'h0, instr}, {32'h0, e.d});
        chk("pop_end", instr_endereco, e.a);
      end
    end
    if (mem_req && mem_ack) begin
      if (!descarta && !descartando) sb.push_back('{a: req_end, d: mem_dado});
      descartando = 1'b0;
    end else if (mem_req && descarta) descartando = 1'b1;
    if (descarta) sb.delete();
    @(posedge clock);
    @(negedge clock);
    if (mem_req && !req_q) begin
      chk("req_end", mem_endereco, endereco);
      req_end = endereco;
    end else if (mem_req) chk("req_hold", mem_endereco, req_end);
    req_q = mem_req;
    if (avanca_pc) begin
      n_av++;
      endereco = endereco + 64'd1;
    end
  endtask
  task automatic wait_req(input int lim);
    for (int n = 0; n < lim && !mem_req; n++) step();
    chk("req_wait", {63'h0, mem_req}, 64'd1);
  endtask
  initial begin
    tab[0] = '{0, 32'h0010_0093, 64'd1};
    tab[1] = '{2, 32'h0020_0113, 64'd2};
    tab[2] = '{1, 32'h0030_0193, 64'd3};
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      endereco = {$urandom, $urandom};
      mem_ack = 1'($urandom_range(0, 1));
      mem_dado = $urandom;
      instr_pronto = 1'($urandom_range(0, 1));
      descarta = 1'($urandom_range(0, 1));
      @(negedge clock);
      chk("rst_out", {avanca_pc, mem_req, instr_valida, 62'h0} | mem_endereco | instr_endereco | {32'h0, instr}, 64'd0);
    end
    endereco = '0; mem_ack = 0; mem_dado = '0; instr_pronto = 0; descarta = 0;
    reset = 1'b1;
    step();
    chk("rst_req", {63'h0, mem_req}, 64'd1);
    // basic fetch: ack one cycle after the request
    step();
    mem_ack = 1; mem_dado = 32'h0000_0013;
    step();
    mem_ack = 0;
    chk("bf_valida", {63'h0, instr_valida}, 64'd1);
    chk("bf_instr", {32'h0, instr}, 64'h13);
    chk("bf_end", instr_endereco, 64'd0);
    chk("bf_av1", {63'h0, avanca_pc}, 64'd1);
    chk("bf_req0", {63'h0, mem_req}, 64'd0);
    step();
    chk("bf_av0", {63'h0, avanca_pc}, 64'd0);
    // backpressure: fill the FIFO with addresses 1..3 via the table
    for (int i = 0; i < 3; i++) begin
      wait_req(4);
      chk("tab_end", mem_endereco, tab[i].end_esp);
      for (int j = 0; j < tab[i].atraso; j++) begin
        step();
        chk("tab_hold", {63'h0, mem_req}, 64'd1);
      end
      mem_ack = 1; mem_dado = tab[i].dado;
      step();
      mem_ack = 0;
      chk("tab_av", {63'h0, avanca_pc}, 64'd1);
      chk("tab_head", instr_endereco, 64'd0);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk("full_noreq", {62'h0, mem_req, avanca_pc}, 64'd0);
    end
    chk("full_av", n_av, 4);
    instr_pronto = 1;
    step();
    instr_pronto = 0;
    chk("bp_head", instr_endereco, 64'd1);
    wait_req(3);
    chk("bp_req4", mem_endereco, 64'd4);
    // push and pop together at count 3, across pointer wrap
    mem_ack = 1; mem_dado = 32'h4444_0044; instr_pronto = 1;
    step();
    mem_ack = 0; instr_pronto = 0;
    chk("pp_head", instr_endereco, 64'd2);
    instr_pronto = 1;
    for (int i = 0; i < 3; i++) begin
      chk("pp_valida", {63'h0, instr_valida}, 64'd1);
      step();
    end
    chk("pp_vazio", {63'h0, instr_valida}, 64'd0);
    step();
    instr_pronto = 0;
    chk("pp_sb", sb.size(), 0);
    // flush with a request in flight, ack 3 cycles later
    wait_req(3);
    chk("fl_end", mem_endereco, 64'd5);
    av0 = n_av;
    descarta = 1;
    step();
    descarta = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("fl_hold", {63'h0, mem_req}, 64'd1);
    end
    mem_ack = 1; mem_dado = 32'hDEAD_BEEF;
    step();
    mem_ack = 0;
    chk("fl_req0", {63'h0, mem_req}, 64'd0);
    chk("fl_valida", {63'h0, instr_valida}, 64'd0);
    step();
    chk("fl_reissue", {63'h0, mem_req}, 64'd1);
    chk("fl_noav", n_av, av0);
    // flush coincident with ack, also discarding a buffered entry
    mem_ack = 1; mem_dado = 32'hA5A5_0005;
    step();
    mem_ack = 0;
    chk("co_valida1", {63'h0, instr_valida}, 64'd1);
    wait_req(3);
    chk("co_end", mem_endereco, 64'd6);
    av0 = n_av;
    mem_ack = 1; descarta = 1; mem_dado = 32'hBAD0_BAD0;
    step();
    mem_ack = 0; descarta = 0;
    chk("co_valida0", {63'h0, instr_valida}, 64'd0);
    chk("co_av", {63'h0, avanca_pc}, 64'd0);
    step();
    chk("co_reissue", mem_endereco, 64'd6);
    chk("co_noav", n_av, av0);
    // random traffic against the scoreboard
    for (int i = 0; i < 80; i++) begin
      mem_ack = mem_req ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_dado = $urandom;
      instr_pronto = 1'($urandom_range(0, 1));
      step();
    end
    mem_ack = 0;
    instr_pronto = 1;
    for (int i = 0; i < 6; i++) step();
    instr_pronto = 0;
    chk("rnd_drain", sb.size(), 0);
    // async reset in the middle of a pending request
    wait_req(4);
    #3 reset = 1'b0;
    #1 chk("ar_req", {63'h0, mem_req}, 64'd0);
    chk("ar_out", mem_endereco | {63'h0, instr_valida}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    req_q = 0; descartando = 0; endereco = '0; sb.delete();
    wait_req(3);
    chk("ar_restart", mem_endereco, 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "timeout");
  end
endmodule
